// File: rtl/cordic_arb.sv
// cordic_arb: round-robin scheduler sharing one CV_CORDIC core; define CORDIC_ARB_QUADFIX_EN for x<0 half-plane pre-rotation
module cordic_arb #(
  parameter int NREQ = 4,
  parameter int W = 16,
  parameter int ITER = 16,
  parameter int EXTRA = 2,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid_i,
  output logic [NREQ-1:0]   req_ready_o,
  input  logic [NREQ*W-1:0] req_x_i,
  input  logic [NREQ*W-1:0] req_y_i,
  output logic              core_start_o,
  output logic [W-1:0]      core_x_o,
  output logic [W-1:0]      core_y_o,
  output logic [W-1:0]      core_yn_o,
  output logic [7:0]        core_n_o,
  input  logic [W-1:0]      core_r_i,
  input  logic [W-1:0]      core_phi_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [IDW-1:0]    res_id_o,
  output logic [W-1:0]      res_r_o,
  output logic [W-1:0]      res_phi_o
);
  localparam int CW = $clog2(ITER + EXTRA + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(ITER + EXTRA - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, HOLD} state_t;
  state_t state_q, state_d;
  logic [IDW-1:0] rr_q, rr_d, id_q, id_d, gnt_id;
  logic gnt_v;
  logic [CW-1:0] cnt_q, cnt_d;
  logic start_q, start_d, valid_q, valid_d;
  logic [W-1:0] x_q, x_d, y_q, y_d, r_q, r_d, phi_q, phi_d;
  logic [W-1:0] sel_x, sel_y, iss_x, iss_y, cap_phi;

  function automatic logic [IDW-1:0] idx(input logic [IDW-1:0] p, input int k);
    return IDW'((int'(p) + k) % NREQ);
  endfunction

  // descending scan so the nearest valid requester at or after rr wins
  always_comb begin
    gnt_v = 1'b0;
    gnt_id = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid_i[idx(rr_q, k)]) begin
        gnt_v = 1'b1;
        gnt_id = idx(rr_q, k);
      end
    end
  end

  assign sel_x = req_x_i[gnt_id*W +: W];
  assign sel_y = req_y_i[gnt_id*W +: W];
  assign req_ready_o = (state_q == IDLE && gnt_v && !rst) ? NREQ'(1) << gnt_id : '0;

`ifdef CORDIC_ARB_QUADFIX_EN
  localparam logic [W-1:0] PI = W'(25736);
  logic flag_q, y_nonneg;

  function automatic logic [W-1:0] sneg(input logic [W-1:0] v);
    return (v == {1'b1, {(W-1){1'b0}}}) ? {1'b0, {(W-1){1'b1}}} : -v;
  endfunction

  assign iss_x = sel_x[W-1] ? sneg(sel_x) : sel_x;
  assign iss_y = sel_x[W-1] ? sneg(sel_y) : sel_y;
  // the issued y is the negated original, so original y>=0 shows up as issued y<=0
  assign y_nonneg = y_q[W-1] || (y_q == '0);
  assign cap_phi = !flag_q ? core_phi_i : y_nonneg ? core_phi_i + PI : core_phi_i - PI;

  always_ff @(posedge clk)
    flag_q <= rst ? 1'b0 : (state_q == IDLE && gnt_v) ? sel_x[W-1] : flag_q;
`else
  assign iss_x = sel_x;
  assign iss_y = sel_y;
  assign cap_phi = core_phi_i;
`endif

  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    id_d = id_q;
    cnt_d = cnt_q;
    start_d = 1'b0;
    valid_d = valid_q;
    x_d = x_q;
    y_d = y_q;
    r_d = r_q;
    phi_d = phi_q;
    case (state_q)
      IDLE: if (gnt_v) begin
        rr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
        id_d = gnt_id;
        x_d = iss_x;
        y_d = iss_y;
        start_d = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: begin
        cnt_d = CNT_INIT;
        state_d = BUSY;
      end
      BUSY: begin
        cnt_d = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
        if (cnt_q == '0) begin
          r_d = core_r_i;
          phi_d = cap_phi;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      default: if (res_ready_i) begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q <= '0;
      id_q <= '0;
      cnt_q <= '0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      x_q <= '0;
      y_q <= '0;
      r_q <= '0;
      phi_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      id_q <= id_d;
      cnt_q <= cnt_d;
      start_q <= start_d;
      valid_q <= valid_d;
      x_q <= x_d;
      y_q <= y_d;
      r_q <= r_d;
      phi_q <= phi_d;
    end
  end

  assign core_start_o = start_q;
  assign core_x_o = x_q;
  assign core_y_o = y_q;
  assign core_yn_o = '0;
  assign core_n_o = 8'(ITER);
  assign res_valid_o = valid_q;
  assign res_id_o = id_q;
  assign res_r_o = r_q;
  assign res_phi_o = phi_q;
endmodule

// File: tb/tb_cordic_arb.sv
// tb_cordic_arb: scoreboard bench for cordic_arb with a behavioural fixed-latency core model
module tb_cordic_arb;
  localparam int NREQ = 4, W = 16, ITER = 16, EXTRA = 2, LAT = ITER + EXTRA + 2;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ-1:0] req_valid, req_ready;
  logic [NREQ*W-1:0] req_x, req_y;
  logic core_start, res_valid, res_ready;
  logic [W-1:0] core_x, core_y, core_yn, core_r, core_phi, res_r, res_phi;
  logic [7:0] core_n;
  logic [1:0] res_id;

  cordic_arb #(.NREQ(NREQ), .W(W), .ITER(ITER), .EXTRA(EXTRA)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_x_i(req_x), .req_y_i(req_y),
    .core_start_o(core_start), .core_x_o(core_x), .core_y_o(core_y),
    .core_yn_o(core_yn), .core_n_o(core_n),
    .core_r_i(core_r), .core_phi_i(core_phi),
    .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_id_o(res_id), .res_r_o(res_r), .res_phi_o(res_phi)
  );

  logic [W-1:0] tx [NREQ] = '{16'h6000, 16'h1000, 16'hA000, 16'h8000};
  logic [W-1:0] ty [NREQ] = '{16'h370A, 16'hE000, 16'h370A, 16'h9000};
  logic [W-1:0] cr [NREQ] = '{16'h6F00, 16'h2400, 16'h6F02, 16'h7FF0};
  logic [W-1:0] cphi [NREQ] = '{16'h0F80, 16'hF000, 16'hF080, 16'h1000};
`ifdef CORDIC_ARB_QUADFIX_EN
  logic [W-1:0] ecx [NREQ] = '{16'h6000, 16'h1000, 16'h6000, 16'h7FFF};
  logic [W-1:0] ecy [NREQ] = '{16'h370A, 16'hE000, 16'hC8F6, 16'h7000};
  logic [W-1:0] ephi [NREQ] = '{16'h0F80, 16'hF000, 16'h5508, 16'hAB78};
`else
  logic [W-1:0] ecx [NREQ] = '{16'h6000, 16'h1000, 16'hA000, 16'h8000};
  logic [W-1:0] ecy [NREQ] = '{16'h370A, 16'hE000, 16'h370A, 16'h9000};
  logic [W-1:0] ephi [NREQ] = '{16'h0F80, 16'hF000, 16'hF080, 16'h1000};
`endif

  // core model: outputs are garbage until ITER+EXTRA edges after the start pulse
  int cc = 0;
  always @(posedge clk)
    if (rst) cc <= 0;
    else if (core_start) cc <= 1;
    else if (cc > 0 && cc < 1000) cc <= cc + 1;
  always_comb begin
    core_r = 16'hDEAD;
    core_phi = 16'hDEAD;
    if (cc >= ITER + EXTRA)
      for (int i = 0; i < NREQ; i++)
        if (core_x == ecx[i] && core_y == ecy[i]) begin
          core_r = cr[i];
          core_phi = cphi[i];
        end
  end

  typedef struct {int id; logic [W-1:0] cx, cy, r, phi; int gc;} job_t;
  job_t iq[$], rq[$], cur;
  int gid_q[$], gcyc_q[$];
  int checks = 0, errors = 0, cyc = 0, rr_m = 0;
  bit busy_m = 0, rv_p = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    int g;
    bit found;
    logic [NREQ-1:0] exp_rdy;
    job_t j;
    if (rst) begin
      iq.delete();
      rq.delete();
      rr_m = 0;
      busy_m = 0;
      rv_p = 0;
      chk("rst_req_ready", 32'(req_ready), 0);
    end else begin
      found = 0;
      g = 0;
      exp_rdy = '0;
      if (!busy_m)
        for (int k = NREQ - 1; k >= 0; k--)
          if (req_valid[(rr_m + k) % NREQ]) begin
            found = 1;
            g = (rr_m + k) % NREQ;
          end
      if (found) exp_rdy = NREQ'(1) << g;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      if (found) begin
        j = '{g, ecx[g], ecy[g], cr[g], ephi[g], cyc};
        iq.push_back(j);
        rq.push_back(j);
        gid_q.push_back(g);
        gcyc_q.push_back(cyc);
        rr_m = (g + 1) % NREQ;
        busy_m = 1;
      end
      if (core_start) begin
        if (iq.size() == 0) chk("core_start_unexpected", 1, 0);
        else begin
          j = iq.pop_front();
          chk("start_cycle", cyc, j.gc + 1);
          chk("core_x", 32'(core_x), 32'(j.cx));
          chk("core_y", 32'(core_y), 32'(j.cy));
          chk("core_n", 32'(core_n), ITER);
          chk("core_yn", 32'(core_yn), 0);
        end
      end
      if (res_valid && !rv_p) begin
        if (rq.size() == 0) chk("res_valid_unexpected", 1, 0);
        else begin
          cur = rq.pop_front();
          chk("res_cycle", cyc, cur.gc + LAT);
          chk("res_id", 32'(res_id), cur.id);
          chk("res_r", 32'(res_r), 32'(cur.r));
          chk("res_phi", 32'(res_phi), 32'(cur.phi));
        end
      end else if (res_valid) begin
        chk("hold_id", 32'(res_id), cur.id);
        chk("hold_r", 32'(res_r), 32'(cur.r));
        chk("hold_phi", 32'(res_phi), 32'(cur.phi));
      end
      if (res_valid && res_ready) begin
        busy_m = 0;
        rv_p = 0;
      end else rv_p = res_valid;
    end
  end

  task automatic wait_ready(input int i, input int lim);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[i] && n < lim);
    if (!req_ready[i]) chk($sformatf("timeout_ready%0d", i), 0, 1);
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy_m && n < lim);
    if (busy_m) chk("timeout_idle", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    req_valid = '0;
    res_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      req_x[i*W +: W] = tx[i];
      req_y[i*W +: W] = ty[i];
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_core_start", 32'(core_start), 0);
    chk("reset_core_x", 32'(core_x), 0);
    chk("reset_core_y", 32'(core_y), 0);
    chk("reset_res_valid", 32'(res_valid), 0);
    chk("reset_res_id", 32'(res_id), 0);
    chk("reset_res_r", 32'(res_r), 0);
    chk("reset_res_phi", 32'(res_phi), 0);
    // single job on requester 0
    @(posedge clk);
    #1 req_valid = 4'b0001;
    wait_ready(0, 10);
    @(posedge clk);
    #1 req_valid = '0;
    wait_idle(60);
    // round robin from a fresh pointer
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    gid_q.delete();
    gcyc_q.delete();
    req_valid = 4'b1111;
    for (int n = 0; n < 300 && gid_q.size() < 5; n++) @(negedge clk);
    @(posedge clk);
    #1 req_valid = '0;
    if (gid_q.size() < 5) chk("rr_grant_count", gid_q.size(), 5);
    else
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("rr_order%0d", i), gid_q[i], i % NREQ);
        if (i > 0) chk($sformatf("rr_spacing%0d", i), gcyc_q[i] - gcyc_q[i-1], LAT + 1);
      end
    wait_idle(60);
    // backpressure with another requester waiting
    res_ready = 1'b0;
    req_valid = 4'b0100;
    wait_ready(2, 10);
    @(posedge clk);
    #1 req_valid = 4'b0001;
    for (int n = 0; n < 60 && !res_valid; n++) @(negedge clk);
    chk("bp_res_valid", 32'(res_valid), 1);
    repeat (10) @(posedge clk);
    #1 res_ready = 1'b1;
    wait_ready(0, 10);
    @(posedge clk);
    #1 req_valid = '0;
    wait_idle(60);
    // reset in the middle of BUSY
    req_valid = 4'b1000;
    wait_ready(3, 10);
    @(posedge clk);
    #1 req_valid = '0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_res_valid", 32'(res_valid), 0);
    chk("midrst_core_start", 32'(core_start), 0);
    chk("midrst_core_x", 32'(core_x), 0);
    repeat (25) @(negedge clk);
    @(posedge clk);
    #1 req_valid = 4'b1111;
    @(negedge clk);
    chk("midrst_rr_zero", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1 req_valid = '0;
    wait_idle(60);
    // both-negative operands on requester 3
    req_valid = 4'b1000;
    wait_ready(3, 10);
    @(posedge clk);
    #1 req_valid = '0;
    wait_idle(60);
    chk("drain_issue", iq.size(), 0);
    chk("drain_result", rq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cordic_arb.md
# cordic_arb

Round-robin scheduler that shares one iterative circular-vectoring CORDIC core (`CV_CORDIC`) between several requesters in the complex-square-root datapath. It accepts complex operands (x, y) over per-requester valid/ready handshakes, issues one `start` pulse per job, and times the core's fixed latency with a counter. It then registers the core's magnitude and angle outputs and returns them tagged with the requester index.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `W`, 16: operand width, signed q3.13 (2's complement).
- `ITER`, 16: iteration count driven on the core's `N` input, 1..255.
- `EXTRA`, 2: core cycles beyond `ITER` before its `r`/`phi` are valid.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset. Shared with the core.
- `req_valid` in NREQ: per-requester job valid.
- `req_ready` out NREQ: one-hot accept pulse.
- `req_x` in NREQ*W: flattened x operands; requester i occupies bits [i*W +: W].
- `req_y` in NREQ*W: flattened y operands, same packing as `req_x`.
- `core_start` out 1: start pulse to the core.
- `core_x` out W: x operand to the core.
- `core_y` out W: y operand to the core.
- `core_yn` out W: constant 0, drives the core's `yn_cv` target.
- `core_N` out 8: constant `ITER`.
- `core_r` in W: core magnitude output.
- `core_phi` in W: core angle output, q3.13 radians.
- `res_valid` out 1: result valid.
- `res_ready` in 1: result accepted.
- `res_id` out clog2(NREQ): index of the requester that owns the result.
- `res_r` out W: registered magnitude.
- `res_phi` out W: registered angle.

## Operation
- FSM states: IDLE, ISSUE, BUSY, HOLD.
- IDLE:
  - If any `req_valid` is high, grant g = the first valid requester at or after pointer `rr`, searching cyclically.
  - Drive `req_ready[g]=1` for that cycle only.
  - Latch `req_x[g]`, `req_y[g]` and g.
  - Set `rr` to (g+1) mod NREQ.
  - Next state: ISSUE.
- ISSUE:
  - `core_start=1` for exactly one cycle.
  - `core_x`/`core_y` carry the latched operands. They stay stable until the FSM returns to IDLE.
  - Load `cnt` with ITER+EXTRA-1.
  - Next state: BUSY.
- BUSY:
  - Decrement `cnt` each cycle.
  - When `cnt`=0, register `core_r`/`core_phi` into `res_r`/`res_phi`, set `res_valid` and go to HOLD.
- HOLD:
  - `res_valid`, `res_id`, `res_r` and `res_phi` are held stable.
  - When `res_ready`=1, clear `res_valid` and go to IDLE.
  - No `req_ready` is asserted in any state other than IDLE.
- Requester rules:
  - `req_valid` must stay high, and `req_x`/`req_y` stable, until `req_ready` is seen.
  - Deasserting `req_valid` before accept withdraws the request. It is legal and is simply not granted.
- Reset values: `req_ready`=0, `core_start`=0, `core_x`=0, `core_y`=0, `res_valid`=0, `res_id`=0, `res_r`=0, `res_phi`=0, `rr`=0, `cnt`=0, state IDLE.
- Reset mid-operation: `rst` in any state aborts the job and forces the reset values on the next edge. No result is produced and the requester is not re-granted. Because the core shares `rst`, it is reset too.
- Simultaneous `res_ready` and new `req_valid` while in HOLD: the FSM returns to IDLE, and the grant happens in the following cycle.

## Timing
- Job accepted at edge k (IDLE cycle with `req_ready` high).
- `core_start` is high in cycle k+1.
- `res_valid` rises in cycle k+ITER+EXTRA+2. With defaults this is k+20.
- Minimum spacing between grants is ITER+EXTRA+3 cycles (21 with defaults), reached when `res_ready` is held high.
- Arbitration is combinational from `req_valid` and `rr`. All outputs are registered except `req_ready`.

## Configuration
- `CORDIC_ARB_QUADFIX_EN` defined: half-plane pre-rotation, because the core converges only for x≥0.
  - When the latched x<0, issue `core_x`=-x and `core_y`=-y. Negating -32768 saturates to 32767.
  - Record a 1-bit flag with the job.
  - At capture, if the flag is set: `res_phi` = `core_phi` + 0x6488 (+π) when the original y≥0, otherwise `core_phi` - 0x6488 (-π).
  - `res_r` is unchanged.
- Not defined: operands pass through unmodified and `res_phi` = `core_phi`. No flag register is built.

## Test plan
- Single job:
  - Stimulus: `req_valid[0]` with x=0x6000, y=0x370A, ITER=16; behavioural core model returns r=0x6F00, phi=0x0F80.
  - Required: `req_ready[0]` at k; one `core_start` pulse at k+1 with `core_x`=0x6000, `core_y`=0x370A, `core_N`=16, `core_yn`=0.
  - Required: `res_valid` at k+20 with `res_id`=0, `res_r`=0x6F00, `res_phi`=0x0F80.
- Round-robin: all four `req_valid` held high continuously → grant order 0,1,2,3,0, with 21 cycles between grants.
- Backpressure: hold `res_ready`=0 for 10 cycles after `res_valid` rises → `res_valid` and all `res_*` values stable, and no `req_ready` asserted during that time.
- Reset mid-BUSY: assert `rst` at k+8 → on the next edge `res_valid`=0, state IDLE, `rr`=0. No result is produced for that job.
- Quadfix, macro defined:
  - Stimulus: x=0xA000, y=0x370A; core model returns phi=0xF080.
  - Required: `core_x`=0x6000, `core_y`=0xC8F6, `res_phi`=0x5508.
- Quadfix, macro not defined: same stimulus → `core_x`=0xA000, `core_y`=0x370A, `res_phi`=0xF080.
